mult_share_arbiter: RTL and testbench

- Shares one pipelined 8x8 multiplier among NUM_REQ requesters.
- Uses round-robin arbitration and a valid/ready handshake on both the request and response sides.
- Drives the multiplier operand inputs and tracks the requester ID of each in-flight operation through a fixed-latency shadow pipeline.
- Buffers products in a result FIFO. A credit scheme guarantees the FIFO never overflows, even though the multiplier cannot be stalled.

---
 rtl/mult_share_arbiter_if.sv | 27 ++
 rtl/mult_share_arbiter.sv | 83 ++++++++
 tb/tb_mult_share_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester, multiplier and response signals of the shared-multiplier arbiter
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [2*WIDTH-1:0]       mul_p;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_data;
  logic                     busy;
  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
  );
  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined multiplier with credit-protected result FIFO
module mult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic reset_n,
  mult_share_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [ID_W-1:0]    r_rr_ptr;
  logic [MUL_LAT-1:0] r_sv;
  logic [ID_W-1:0]    r_sid [MUL_LAT];
  logic [ID_W-1:0]    r_mem_id [FIFO_DEPTH];
  logic [2*WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic               w_credit;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [ID_W-1:0]    w_gnt;
  logic [ID_W-1:0]    w_idx;
  // a slot is free only if neither queued nor in-flight results already claim it; no grants while in reset
  assign w_credit = reset_n && ((int'(r_cnt) + $countones(r_sv)) < FIFO_DEPTH);
  // round-robin search upward from r_rr_ptr; smallest offset is assigned last so it wins
  always_comb begin
    w_issue = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (w_credit && bus.req_valid[w_idx]) begin
        w_issue = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end
  assign bus.req_ready = w_issue ? (NUM_REQ'(1) << w_gnt) : '0;
  assign bus.mul_a     = w_issue ? bus.req_a[w_gnt*WIDTH +: WIDTH] : '0;
  assign bus.mul_b     = w_issue ? bus.req_b[w_gnt*WIDTH +: WIDTH] : '0;
  assign w_push        = r_sv[MUL_LAT-1];
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = (r_cnt != '0);
  assign bus.rsp_id    = bus.rsp_valid ? r_mem_id[r_rp] : '0;
  assign bus.rsp_data  = bus.rsp_valid ? r_mem_data[r_rp] : '0;
  assign bus.busy      = (|r_sv) || bus.rsp_valid;
  // pointer, shadow pipeline tracking the multiplier, and FIFO occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_sv     <= '0;
      for (int k = 0; k < MUL_LAT; k++) r_sid[k] <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_issue) r_rr_ptr <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
      r_sv[0]  <= w_issue;
      r_sid[0] <= w_gnt;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_sv[k]  <= r_sv[k-1];
        r_sid[k] <= r_sid[k-1];
      end
      if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  // result storage needs no reset: entries are only read while r_cnt says they hold data
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wp]   <= r_sid[MUL_LAT-1];
      r_mem_data[r_wp] <= bus.mul_p;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) w_push |-> (int'(r_cnt) < FIFO_DEPTH));
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: random and directed stimulus against a queue-based reference of the arbiter
module tb_mult_share_arbiter;
  localparam int N = 4, W = 8, LAT = 2, DEPTH = 4, IDW = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  mult_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) bus ();
  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  // two-stage pipelined multiplier
  logic [2*W-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= bus.mul_a * bus.mul_b;
    p2 <= p1;
  end
  assign bus.mul_p = p2;
  int vectors = 0, miscompares = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference: grant = first valid upward from the last winner + 1 while issued-minus-popped < DEPTH;
  // each result becomes visible LAT+1 cycles after its issue and results leave in issue order
  typedef struct {int id; int data; int avail;} exp_t;
  exp_t q[$];
  int m_out = 0, m_rr = 0, cyc = 0;
  always @(negedge clk) begin
    int g;
    bit ev;
    logic [N-1:0] er;
    if (!reset_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      q.delete();
      m_out = 0;
      m_rr = 0;
    end else begin
      g = -1;
      if (m_out < DEPTH)
        for (int k = 0; k < N && g < 0; k++)
          if (bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", bus.req_ready, er);
      chk("busy", bus.busy, m_out > 0);
      ev = q.size() > 0 && q[0].avail <= cyc;
      chk("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        chk("rsp_id", bus.rsp_id, q[0].id);
        chk("rsp_data", bus.rsp_data, q[0].data);
        if (bus.rsp_ready) begin
          void'(q.pop_front());
          m_out--;
        end
      end
      if (g >= 0) begin
        q.push_back('{g, int'(bus.req_a[g*W +: W]) * int'(bus.req_b[g*W +: W]), cyc + LAT + 1});
        m_out++;
        m_rr = (g + 1) % N;
      end
    end
    cyc++;
  end
  logic [N-1:0] hs = '0;
  int n_iss;
  task automatic tick();
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(int i, bit v, int a, int b);
    bus.req_valid[i] = v;
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);
    repeat (n) tick();
  endtask
  task automatic one(int i, int a, int b);
    set_req(i, 1, a, b);
    for (int t = 0; t < 20; t++) begin
      tick();
      if (hs[i]) break;
    end
    chk("grant_seen", hs[i], 1);
    set_req(i, 0, 0, 0);
  endtask
  task automatic renew(logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[i] && hs[i]) set_req(i, 1, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    idle(2);
    // single request with latency and busy timing
    one(1, 12, 11);
    chk("lat_c1", bus.rsp_valid, 0);
    tick();
    chk("lat_c2", bus.rsp_valid, 0);
    tick();
    chk("lat_c3", bus.rsp_valid, 1);
    chk("single_id", bus.rsp_id, 1);
    chk("single_data", bus.rsp_data, 132);
    tick();
    chk("busy_after_pop", bus.busy, 0);
    idle(3);
    // all requesters continuously valid
    for (int i = 0; i < N; i++) set_req(i, 1, i + 1, 10);
    repeat (16) tick();
    idle(6);
    // backpressure fills exactly DEPTH credits
    bus.rsp_ready = 1'b0;
    set_req(0, 1, 3, 7);
    set_req(2, 1, 9, 4);
    n_iss = 0;
    repeat (10) begin
      tick();
      n_iss += $countones(hs);
      renew(4'b0101);
    end
    chk("bp_issues", n_iss, DEPTH);
    bus.rsp_ready = 1'b1;
    tick();
    n_iss += $countones(hs);
    renew(4'b0101);
    bus.rsp_ready = 1'b0;
    repeat (4) begin
      tick();
      n_iss += $countones(hs);
      renew(4'b0101);
    end
    chk("bp_after_pop", n_iss, DEPTH + 1);
    bus.rsp_ready = 1'b1;
    idle(10);
    // operand extremes
    one(0, 255, 255);
    one(1, 0, 200);
    one(2, 255, 1);
    one(3, 255, 255);
    idle(6);
    // reset with two results queued and two in flight
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (4) begin
      tick();
      renew(4'b1111);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.rsp_valid, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_ready", bus.req_ready, 0);
    chk("async_rst_data", bus.rsp_data, 0);
    tick();
    tick();
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    chk("first_grant_after_rst", hs, 4'b0001);
    repeat (6) begin
      renew(4'b1111);
      tick();
    end
    idle(8);
    // sparse wrap from requester 3 to requester 0
    set_req(3, 1, 5, 6);
    for (int t = 0; t < 10; t++) begin
      tick();
      if (hs[3]) break;
    end
    chk("wrap_grant3", hs[3], 1);
    set_req(3, 0, 0, 0);
    set_req(0, 1, 7, 8);
    tick();
    chk("wrap_no_idle", hs, 4'b0001);
    for (int i = 0; i < N; i++) set_req(i, 1, i + 20, 3);
    tick();
    chk("rr_after_wrap", hs, 4'b0010);
    idle(8);
    // randomized traffic with varying backpressure
    for (int c = 0; c < 1500; c++) begin
      bus.rsp_ready = ((c / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || hs[i])
          set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 255), $urandom_range(0, 255));
        else if ($urandom_range(0, 19) == 0)
          bus.req_valid[i] = 1'b0;
      end
      tick();
    end
    // drain with a bounded wait
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 40 && bus.busy; t++) tick();
    chk("drain_busy", bus.busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
